// File: rtl/noc_pktgen_pkg.sv
// Shared definitions for the NoC packet generator and its receive checker:
// FSM state encoding, header field offsets and payload pattern field widths.
package noc_pktgen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_GAP,
        ST_DONE
    } pktgen_state_e;

    // Payload flit pattern: {zeros, seq[15:0], index[15:0]}
    localparam int SEQ_W = 16;
    localparam int IDX_W = 16;

    // Destination id sits in the top DEST_W bits of the header flit
    function automatic int dest_lsb(input int fw, input int dw);
        return fw - dw;
    endfunction

    // Source id sits directly below the destination id
    function automatic int src_lsb(input int fw, input int dw);
        return fw - 2 * dw;
    endfunction

endpackage

// File: rtl/noc_pktgen_stats.sv
// Saturating stall-cycle counter for the packet generator.
// Ports: clk, rst (sync, active-low), clear (run start), stall (cycle
// with valid held but not accepted), stall_cnt (registered count).
module noc_pktgen_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        stall,
    output logic [31:0] stall_cnt
);

    logic [31:0] cnt_d;
    logic [31:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: rtl/noc_packet_gen.sv
// Packet transmitter for one mesh injection port: after start, sends
// cfg_count packets (header + cfg_len payload flits) to cfg_dest with
// cfg_gap idle cycles between packets.
// Ports: clk, rst (sync, active-low), start, cfg_dest/len/count/gap,
// busy, done, pkt_sent, out_flit/out_last/out_valid, out_ready, and
// stall_cnt when NOC_PKTGEN_STATS_EN is defined.
module noc_packet_gen
    import noc_pktgen_pkg::*;
#(
    parameter int FLIT_WIDTH = 34,
    parameter int NODES      = 16,
    parameter int DEST_W     = 4,
    parameter int SRC_ID     = 0,
    parameter int LEN_W      = 8,
    parameter int COUNT_W    = 16,
    parameter int GAP_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DEST_W-1:0]     cfg_dest,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [COUNT_W-1:0]    cfg_count,
    input  logic [GAP_W-1:0]      cfg_gap,
    output logic                  busy,
    output logic                  done,
    output logic [COUNT_W-1:0]    pkt_sent,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef NOC_PKTGEN_STATS_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int DEST_LSB = dest_lsb(FLIT_WIDTH, DEST_W);
    localparam int SRC_LSB  = src_lsb(FLIT_WIDTH, DEST_W);
    localparam logic [DEST_W-1:0] SRC_V = DEST_W'(SRC_ID);

    if (FLIT_WIDTH < 32 || FLIT_WIDTH < 2 * DEST_W + 16) begin : g_bad_fw
        $error("noc_packet_gen: FLIT_WIDTH too small");
    end
    if (DEST_W < $clog2(NODES)) begin : g_bad_dw
        $error("noc_packet_gen: DEST_W too small for NODES");
    end

    function automatic logic [FLIT_WIDTH-1:0] hdr_flit(
        input logic [DEST_W-1:0] d,
        input logic [SEQ_W-1:0]  s
    );
        logic [FLIT_WIDTH-1:0] f;
        f = '0;
        f[DEST_LSB +: DEST_W] = d;
        f[SRC_LSB +: DEST_W]  = SRC_V;
        f[SEQ_W-1:0]          = s;
        return f;
    endfunction

    function automatic logic [FLIT_WIDTH-1:0] pay_flit(
        input logic [SEQ_W-1:0] s,
        input logic [IDX_W-1:0] k
    );
        logic [FLIT_WIDTH-1:0] f;
        f = '0;
        f[IDX_W +: SEQ_W] = s;
        f[IDX_W-1:0]      = k;
        return f;
    endfunction

    pktgen_state_e         state_q, state_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0]      k_q, k_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [COUNT_W-1:0]    pkt_sent_q, pkt_sent_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;

    logic               accept;
    logic               xfer;
    logic               pkt_end;
    logic [LEN_W-1:0]   k_nxt;
    logic [SEQ_W-1:0]   seq_nxt;
    logic [COUNT_W-1:0] pkt_inc;

    assign accept  = (state_q == ST_IDLE) && start;
    assign xfer    = valid_q && out_ready;
    assign k_nxt   = k_q + LEN_W'(1);
    assign seq_nxt = seq_q + SEQ_W'(1);
    // Saturate rather than wrap; unreachable since count shares the width
    assign pkt_inc = (pkt_sent_q == '1) ? pkt_sent_q
                                        : pkt_sent_q + COUNT_W'(1);

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        len_d      = len_q;
        count_d    = count_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        k_d        = k_q;
        seq_d      = seq_q;
        pkt_sent_d = pkt_sent_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        last_d     = last_q;
        flit_d     = flit_q;
        pkt_end    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dest_d     = cfg_dest;
                    len_d      = cfg_len;
                    count_d    = cfg_count;
                    gap_d      = cfg_gap;
                    seq_d      = '0;
                    pkt_sent_d = '0;
                    busy_d     = 1'b1;
                    if (cfg_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HEADER;
                        valid_d = 1'b1;
                        flit_d  = hdr_flit(cfg_dest, '0);
                        last_d  = (cfg_len == '0);
                    end
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    if (len_q == '0) begin
                        pkt_end = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                        k_d     = '0;
                        flit_d  = pay_flit(seq_q, '0);
                        last_d  = (len_q == LEN_W'(1));
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (last_q) begin
                        pkt_end = 1'b1;
                    end else begin
                        k_d    = k_nxt;
                        flit_d = pay_flit(seq_q, IDX_W'(k_nxt));
                        last_d = (k_nxt == len_q - LEN_W'(1));
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = ST_HEADER;
                    valid_d = 1'b1;
                    flit_d  = hdr_flit(dest_q, seq_q);
                    last_d  = (len_q == '0);
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pkt_end) begin
            pkt_sent_d = pkt_inc;
            seq_d      = seq_nxt;
            if (pkt_inc == count_q) begin
                state_d = ST_DONE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                flit_d  = '0;
            end else if (gap_q != '0) begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_q;
                valid_d   = 1'b0;
                last_d    = 1'b0;
                flit_d    = '0;
            end else begin
                state_d = ST_HEADER;
                valid_d = 1'b1;
                flit_d  = hdr_flit(dest_q, seq_nxt);
                last_d  = (len_q == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dest_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            k_q        <= '0;
            seq_q      <= '0;
            pkt_sent_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            flit_q     <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            len_q      <= len_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            k_q        <= k_d;
            seq_q      <= seq_d;
            pkt_sent_q <= pkt_sent_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            flit_q     <= flit_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pkt_sent  = pkt_sent_q;
    assign out_flit  = flit_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

`ifdef NOC_PKTGEN_STATS_EN
    noc_pktgen_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .stall     (valid_q && !out_ready),
        .stall_cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_noc_packet_gen.sv
// Self-checking bench for noc_packet_gen: scoreboard of expected flits,
// per-scenario tasks with inline timing checks.
module tb_noc_packet_gen;

    localparam int FW  = 34;
    localparam int SRC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    cfg_dest = '0;
    logic [7:0]    cfg_len = '0;
    logic [15:0]   cfg_count = '0;
    logic [7:0]    cfg_gap = '0;
    logic          busy, done, out_last, out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   pkt_sent;
    logic [FW-1:0] out_flit;
`ifdef NOC_PKTGEN_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [FW-1:0] flit;
        logic          last;
    } exp_t;
    exp_t sb[$];

    noc_packet_gen #(
        .FLIT_WIDTH(FW), .NODES(16), .DEST_W(4), .SRC_ID(SRC),
        .LEN_W(8), .COUNT_W(16), .GAP_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_dest(cfg_dest), .cfg_len(cfg_len),
        .cfg_count(cfg_count), .cfg_gap(cfg_gap),
        .busy(busy), .done(done), .pkt_sent(pkt_sent),
        .out_flit(out_flit), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef NOC_PKTGEN_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] hdr(input logic [3:0] d, input logic [15:0] s);
        logic [3:0] src4;
        src4 = SRC[3:0];
        return {d, src4, 10'b0, s};
    endfunction

    function automatic logic [FW-1:0] pay(input logic [15:0] s, input logic [15:0] k);
        return {2'b0, s, k};
    endfunction

    // Scoreboard: every accepted flit is popped and compared
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: flit=%h last=%b, none expected", out_flit, out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_flit !== e.flit || out_last !== e.last) begin
                    errors++;
                    $display("FAIL sb_flit: got %h/%b, want %h/%b", out_flit, out_last, e.flit, e.last);
                end
            end
        end
    end

    task automatic kick(input logic [3:0] d, input logic [7:0] l,
                        input logic [15:0] c, input logic [7:0] g);
        @(posedge clk); #1;
        cfg_dest = d; cfg_len = l; cfg_count = c; cfg_gap = g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, pkt_sent, out_valid, out_last, out_flit} !== '0) begin
            errors++;
            $display("FAIL reset_vals: busy=%b done=%b sent=%0d v=%b l=%b f=%h, want all 0",
                     busy, done, pkt_sent, out_valid, out_last, out_flit);
        end
`ifdef NOC_PKTGEN_STATS_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d want 0", stall_cnt);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        int t = 0, t_last = -1, t_done = -1, n_last = 0;
        sb.push_back('{hdr(4'd5, 16'd0), 1'b0});
        sb.push_back('{pay(16'd0, 16'd0), 1'b0});
        sb.push_back('{pay(16'd0, 16'd1), 1'b0});
        sb.push_back('{pay(16'd0, 16'd2), 1'b1});
        kick(4'd5, 8'd3, 16'd1, 8'd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: busy=%b valid=%b want 1/1", busy, out_valid);
        end
        while (t_done < 0 && t < 200) begin
            if (out_valid && out_last) begin n_last++; t_last = t; end
            if (done) t_done = t;
            else begin @(negedge clk); t++; end
        end
        checks++;
        if (t_done < 0 || t_done - t_last != 2) begin
            errors++;
            $display("FAIL single_done: done at %0d last at %0d, want last+2", t_done, t_last);
        end
        checks++;
        if (n_last != 1 || t_last != 3) begin
            errors++;
            $display("FAIL single_last: count %0d at %0d, want 1 at 3", n_last, t_last);
        end
        checks++;
        if (pkt_sent !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_sent: sent=%0d busy=%b want 1/0", pkt_sent, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_sb: %0d left want 0", sb.size());
        end
    endtask

    task automatic test_gap();
        int t = 0, t_done = -1;
        int vt[$];
        for (int i = 0; i < 3; i++) sb.push_back('{hdr(4'd9, 16'(i)), 1'b1});
        kick(4'd9, 8'd0, 16'd3, 8'd2);
        while (t_done < 0 && t < 200) begin
            @(negedge clk);
            if (out_valid) vt.push_back(t);
            if (done) t_done = t;
            t++;
        end
        checks++;
        if (vt.size() != 3) begin
            errors++;
            $display("FAIL gap_flits: got %0d want 3", vt.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (vt[i] - vt[i-1] != 3) begin
                    errors++;
                    $display("FAIL gap_idle: spacing %0d want 3", vt[i] - vt[i-1]);
                end
            end
        end
        checks++;
        if (t_done < 0 || pkt_sent !== 16'd3) begin
            errors++;
            $display("FAIL gap_done: done_t=%0d sent=%0d want 3", t_done, pkt_sent);
        end
    endtask

    task automatic test_stall();
        int t = 0;
        logic [FW-1:0] want;
        sb.push_back('{hdr(4'd2, 16'd0), 1'b0});
        for (int k = 0; k < 4; k++) sb.push_back('{pay(16'd0, 16'(k)), k == 3});
        kick(4'd2, 8'd4, 16'd1, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        want = pay(16'd0, 16'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_flit !== want) begin
                errors++;
                $display("FAIL stall_hold: v=%b f=%h want 1/%h", out_valid, out_flit, want);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (!done && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!done || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_done: done=%b left=%0d want 1/0", done, sb.size());
        end
`ifdef NOC_PKTGEN_STATS_EN
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
        end
`endif
    endtask

    task automatic test_count_zero();
        logic [2:0] want_busy, want_done;
        want_busy = 3'b001;
        want_done = 3'b010;
        kick(4'd1, 8'd2, 16'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== want_busy[i] || done !== want_done[i] || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_cyc%0d: busy=%b done=%b v=%b want %b/%b/0",
                         i, busy, done, out_valid, want_busy[i], want_done[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        int t = 0, extra = 0;
        for (int p = 0; p < 2; p++) begin
            sb.push_back('{hdr(4'd7, 16'(p)), 1'b0});
            sb.push_back('{pay(16'(p), 16'd0), 1'b1});
        end
        kick(4'd7, 8'd1, 16'd2, 8'd1);
        @(posedge clk); #1;
        cfg_dest = 4'd1; cfg_len = 8'd5; cfg_count = 16'd9; cfg_gap = 8'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!done || pkt_sent !== 16'd2) begin
            errors++;
            $display("FAIL busy_run: done=%b sent=%0d want 1/2", done, pkt_sent);
        end
        repeat (5) begin @(negedge clk); if (out_valid || busy) extra++; end
        checks++;
        if (extra != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL busy_extra: active=%0d left=%0d want 0/0", extra, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        sb.push_back('{hdr(4'd4, 16'd0), 1'b0});
        sb.push_back('{pay(16'd0, 16'd0), 1'b0});
        sb.push_back('{pay(16'd0, 16'd1), 1'b0});
        kick(4'd4, 8'd6, 16'd2, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, pkt_sent, out_valid, out_last, out_flit} !== '0) begin
            errors++;
            $display("FAIL rstmid_vals: busy=%b done=%b sent=%0d v=%b f=%h want 0",
                     busy, done, pkt_sent, out_valid, out_flit);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rstmid_sb: %0d left want 0", sb.size());
        end
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        sb.push_back('{hdr(4'd4, 16'd0), 1'b1});
        kick(4'd4, 8'd0, 16'd1, 8'd0);
        while (!done && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (!done || sb.size() != 0 || pkt_sent !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_fresh: done=%b left=%0d sent=%0d want 1/0/1",
                     done, sb.size(), pkt_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_stall();
        test_count_zero();
        test_start_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
